// File: rtl/ea_sequencer.sv
// Effective-address and operand sequencer: runs the operand, index, pointer,
// page-fix, data and read-modify-write bus cycles for every memory addressing mode.
module ea_sequencer #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 16,
  parameter int ZP_WRAP = 1,
  parameter int RMW_EN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        mode,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] pc,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [WIDTH-1:0]  di,
  output logic [ADDR_W-1:0] ab,
  output logic [WIDTH-1:0]  dout,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] ea,
  output logic [WIDTH-1:0]  rdata,
  output logic [1:0]        pc_adv,
  output logic [3:0]        dbg_state
);

  // Handshake: start is sampled only while busy is low (including the done
  // cycle); done is a single-cycle pulse and ea/rdata/pc_adv stay valid until
  // the next done.

  typedef enum logic [3:0] {
    S_IDLE, S_OP0, S_OP1, S_IDX, S_PTR0, S_PTR1, S_FIX, S_DATA, S_RMW1, S_RMW2
  } state_t;

  localparam logic [3:0] M_IMM  = 4'd0;
  localparam logic [3:0] M_ZP   = 4'd1;
  localparam logic [3:0] M_ZPX  = 4'd2;
  localparam logic [3:0] M_ZPY  = 4'd3;
  localparam logic [3:0] M_ABS  = 4'd4;
  localparam logic [3:0] M_ABSY = 4'd6;
  localparam logic [3:0] M_INDX = 4'd7;
  localparam logic [3:0] M_INDY = 4'd8;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_RMW = 2'd2;

  localparam logic [WIDTH-1:0] ZERO_B = '0;

  state_t             state, state_n;
  logic [3:0]         mode_r, mode_n;
  logic [1:0]         op_r, op_n;
  logic [WIDTH-1:0]   base_r, base_n;
  logic [WIDTH-1:0]   p_r, p_n;
  logic [WIDTH-1:0]   lo_r, lo_n;
  logic [WIDTH-1:0]   hi_r, hi_n;
  logic               c_r, c_n;
  logic [WIDTH-1:0]   d_r, d_n;

  logic               fin, fin_err;
  logic [ADDR_W-1:0]  fin_ea;
  logic [WIDTH-1:0]   fin_rdata;
  logic [1:0]         fin_adv;

  logic [WIDTH-1:0]   idx;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   p_inc;
  logic [ADDR_W-1:0]  t_addr;
  logic [1:0]         adv_mode;

  assign idx      = (mode_r == M_ZPY || mode_r == M_ABSY || mode_r == M_INDY) ? y : x;
  assign p_inc    = p_r + {{(WIDTH-1){1'b0}}, 1'b1};
  assign t_addr   = {hi_r, lo_r};
  assign adv_mode = (mode_r >= M_ABS && mode_r <= M_ABSY) ? 2'd2 : 2'd1;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_n   = state;
    mode_n    = mode_r;
    op_n      = op_r;
    base_n    = base_r;
    p_n       = p_r;
    lo_n      = lo_r;
    hi_n      = hi_r;
    c_n       = c_r;
    d_n       = d_r;
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_ea    = ea;
    fin_rdata = rdata;
    fin_adv   = pc_adv;
    ab        = pc;
    we        = 1'b0;
    dout      = '0;
    sum       = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          mode_n = mode;
          if (op == OP_WR)                      op_n = OP_WR;
          else if (op == OP_RMW && RMW_EN != 0) op_n = OP_RMW;
          else                                  op_n = OP_RD;
          if (mode > M_INDY) begin
            fin     = 1'b1;
            fin_err = 1'b1;
            fin_adv = 2'd0;
          end else begin
            state_n = S_OP0;
          end
        end
      end
      S_OP0: begin
        ab = pc;
        case (mode_r)
          M_IMM: begin
            fin = 1'b1;
            if (op_r == OP_WR) begin
              fin_err = 1'b1;
              fin_adv = 2'd0;
            end else begin
              fin_rdata = di;
              fin_ea    = pc;
              fin_adv   = 2'd1;
            end
          end
          M_ZP: begin
            lo_n    = di;
            hi_n    = ZERO_B;
            state_n = S_DATA;
          end
          M_ZPX, M_ZPY, M_INDX: begin
            base_n  = di;
            state_n = S_IDX;
          end
          M_INDY: begin
            p_n     = di;
            state_n = S_PTR0;
          end
          default: begin
            base_n  = di;
            state_n = S_OP1;
          end
        endcase
      end
      S_OP1: begin
        ab   = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        hi_n = di;
        if (mode_r == M_ABS) begin
          lo_n    = base_r;
          state_n = S_DATA;
        end else begin
          sum     = {1'b0, base_r} + {1'b0, idx};
          lo_n    = sum[WIDTH-1:0];
          c_n     = sum[WIDTH];
          state_n = (sum[WIDTH] || op_r != OP_RD) ? S_FIX : S_DATA;
        end
      end
      S_IDX: begin
        ab  = {ZERO_B, base_r};
        sum = {1'b0, base_r} + {1'b0, idx};
        if (mode_r == M_INDX) begin
          p_n     = sum[WIDTH-1:0];
          state_n = S_PTR0;
        end else begin
          lo_n    = sum[WIDTH-1:0];
          hi_n    = (ZP_WRAP != 0) ? ZERO_B : {{(WIDTH-1){1'b0}}, sum[WIDTH]};
          state_n = S_DATA;
        end
      end
      S_PTR0: begin
        ab      = {ZERO_B, p_r};
        lo_n    = di;
        state_n = S_PTR1;
      end
      S_PTR1: begin
        // Pointer high byte always wraps inside page zero.
        ab   = {ZERO_B, p_inc};
        hi_n = di;
        if (mode_r == M_INDX) begin
          state_n = S_DATA;
        end else begin
          sum     = {1'b0, lo_r} + {1'b0, idx};
          lo_n    = sum[WIDTH-1:0];
          c_n     = sum[WIDTH];
          state_n = (sum[WIDTH] || op_r != OP_RD) ? S_FIX : S_DATA;
        end
      end
      S_FIX: begin
        ab      = t_addr;
        hi_n    = hi_r + {{(WIDTH-1){1'b0}}, c_r};
        state_n = S_DATA;
      end
      S_DATA: begin
        ab = t_addr;
        if (op_r == OP_WR) begin
          we      = 1'b1;
          dout    = wdata;
          fin     = 1'b1;
          fin_ea  = t_addr;
          fin_adv = adv_mode;
        end else begin
          d_n = di;
          if (op_r == OP_RMW) begin
            state_n = S_RMW1;
          end else begin
            fin       = 1'b1;
            fin_rdata = di;
            fin_ea    = t_addr;
            fin_adv   = adv_mode;
          end
        end
      end
      S_RMW1: begin
        ab      = t_addr;
        we      = 1'b1;
        dout    = d_r;
        state_n = S_RMW2;
      end
      S_RMW2: begin
        ab        = t_addr;
        we        = 1'b1;
        dout      = wdata;
        fin       = 1'b1;
        fin_rdata = d_r;
        fin_ea    = t_addr;
        fin_adv   = adv_mode;
      end
      default: state_n = S_IDLE;
    endcase
    if (fin) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      mode_r <= '0;
      op_r   <= '0;
      base_r <= '0;
      p_r    <= '0;
      lo_r   <= '0;
      hi_r   <= '0;
      c_r    <= 1'b0;
      d_r    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      ea     <= '0;
      rdata  <= '0;
      pc_adv <= '0;
    end else begin
      state  <= state_n;
      mode_r <= mode_n;
      op_r   <= op_n;
      base_r <= base_n;
      p_r    <= p_n;
      lo_r   <= lo_n;
      hi_r   <= hi_n;
      c_r    <= c_n;
      d_r    <= d_n;
      done   <= fin;
      err    <= fin_err;
      ea     <= fin_ea;
      rdata  <= fin_rdata;
      pc_adv <= fin_adv;
    end
  end

endmodule

// File: tb/tb_ea_sequencer.sv
// Directed bench for ea_sequencer: a byte memory answers the bus, each task
// runs one addressing scenario and checks bus trace, timing and results.
module tb_ea_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mode;
  logic [1:0]  op;
  logic [15:0] pc;
  logic [7:0]  x, y, wdata;
  logic [7:0]  di, di2;
  logic [15:0] ab, ab2, ea, ea2;
  logic [7:0]  dout, dout2, rdata, rdata2;
  logic        we, we2, busy, busy2, done, done2, err, err2;
  logic [1:0]  pc_adv, pc_adv2;
  logic [3:0]  dbg_state, dbg_state2;

  bit [7:0]    mem [0:65535];
  logic [15:0] tr_ab[$];
  logic        tr_we[$];
  logic [7:0]  tr_do[$];
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  assign di  = mem[ab];
  assign di2 = mem[ab2];

  ea_sequencer #(.WIDTH(8), .ADDR_W(16), .ZP_WRAP(1), .RMW_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .op(op), .pc(pc),
    .x(x), .y(y), .wdata(wdata), .di(di), .ab(ab), .dout(dout), .we(we),
    .busy(busy), .done(done), .err(err), .ea(ea), .rdata(rdata),
    .pc_adv(pc_adv), .dbg_state(dbg_state)
  );

  ea_sequencer #(.WIDTH(8), .ADDR_W(16), .ZP_WRAP(0), .RMW_EN(1)) dut_nw (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .op(op), .pc(pc),
    .x(x), .y(y), .wdata(wdata), .di(di2), .ab(ab2), .dout(dout2), .we(we2),
    .busy(busy2), .done(done2), .err(err2), .ea(ea2), .rdata(rdata2),
    .pc_adv(pc_adv2), .dbg_state(dbg_state2)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[ab] <= dout;
  end

  // driver: issue one request and record busy bus cycles until done
  task automatic run_op(input logic [3:0] m, input logic [1:0] o, input bit now,
                        output int done_cyc);
    tr_ab.delete();
    tr_we.delete();
    tr_do.delete();
    if (!now) @(negedge clk);
    start = 1'b1;
    mode  = m;
    op    = o;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy) begin
        tr_ab.push_back(ab);
        tr_we.push_back(we);
        tr_do.push_back(dout);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic check_trace(input string name);
    n_cmp++;
    if (tr_ab.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s bus_len: got %0d want %0d", name, tr_ab.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < tr_ab.size()) begin
        n_cmp++;
        if (tr_ab[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL %s ab[%0d]: got %h want %h", name, i, tr_ab[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; mode = '0; op = '0;
    pc = 16'h0200; x = '0; y = '0; wdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (ea !== 16'h0000)  begin n_bad++; $display("FAIL rst_ea: got %h want 0000", ea); end
    n_cmp++; if (rdata !== 8'h00)  begin n_bad++; $display("FAIL rst_rdata: got %h want 00", rdata); end
    n_cmp++; if (pc_adv !== 2'd0)  begin n_bad++; $display("FAIL rst_adv: got %0d want 0", pc_adv); end
    n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (we !== 1'b0)      begin n_bad++; $display("FAIL rst_we: got %b want 0", we); end
    n_cmp++; if (ab !== 16'h0200)  begin n_bad++; $display("FAIL rst_ab: got %h want 0200", ab); end
    n_cmp++; if (dout !== 8'h00)   begin n_bad++; $display("FAIL rst_do: got %h want 00", dout); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_imm;
    int dc;
    mem[16'h0200] = 8'hA5;
    run_op(4'd0, 2'd0, 1'b0, dc);
    exp_q = '{16'h0200};
    check_trace("imm");
    n_cmp++; if (dc !== 2)          begin n_bad++; $display("FAIL imm_done_cyc: got %0d want 2", dc); end
    n_cmp++; if (rdata !== 8'hA5)   begin n_bad++; $display("FAIL imm_rdata: got %h want a5", rdata); end
    n_cmp++; if (ea !== 16'h0200)   begin n_bad++; $display("FAIL imm_ea: got %h want 0200", ea); end
    n_cmp++; if (pc_adv !== 2'd1)   begin n_bad++; $display("FAIL imm_adv: got %0d want 1", pc_adv); end
  endtask

  task automatic test_zp_read;
    int dc;
    mem[16'h0200] = 8'h10;
    mem[16'h0010] = 8'h5A;
    run_op(4'd1, 2'd0, 1'b0, dc);
    exp_q = '{16'h0200, 16'h0010};
    check_trace("zp");
    n_cmp++; if (dc !== 3)          begin n_bad++; $display("FAIL zp_done_cyc: got %0d want 3", dc); end
    n_cmp++; if (rdata !== 8'h5A)   begin n_bad++; $display("FAIL zp_rdata: got %h want 5a", rdata); end
    n_cmp++; if (ea !== 16'h0010)   begin n_bad++; $display("FAIL zp_ea: got %h want 0010", ea); end
    n_cmp++; if (pc_adv !== 2'd1)   begin n_bad++; $display("FAIL zp_adv: got %0d want 1", pc_adv); end
    n_cmp++; if (err !== 1'b0)      begin n_bad++; $display("FAIL zp_err: got %b want 0", err); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL zp_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_zpx_wrap;
    int dc;
    mem[16'h0200] = 8'hF0;
    mem[16'h0010] = 8'h77;
    mem[16'h0110] = 8'h88;
    x = 8'h20;
    run_op(4'd2, 2'd0, 1'b0, dc);
    exp_q = '{16'h0200, 16'h00F0, 16'h0010};
    check_trace("zpx");
    n_cmp++; if (dc !== 4)          begin n_bad++; $display("FAIL zpx_done_cyc: got %0d want 4", dc); end
    n_cmp++; if (ea !== 16'h0010)   begin n_bad++; $display("FAIL zpx_ea_wrap: got %h want 0010", ea); end
    n_cmp++; if (rdata !== 8'h77)   begin n_bad++; $display("FAIL zpx_rdata_wrap: got %h want 77", rdata); end
    n_cmp++; if (ea2 !== 16'h0110)  begin n_bad++; $display("FAIL zpx_ea_nowrap: got %h want 0110", ea2); end
    n_cmp++; if (rdata2 !== 8'h88)  begin n_bad++; $display("FAIL zpx_rdata_nowrap: got %h want 88", rdata2); end
  endtask

  task automatic test_absx;
    int dc;
    mem[16'h0200] = 8'hFF;
    mem[16'h0201] = 8'h12;
    mem[16'h1300] = 8'hC3;
    mem[16'h12FF] = 8'h3C;
    x = 8'h01;
    run_op(4'd5, 2'd0, 1'b0, dc);
    exp_q = '{16'h0200, 16'h0201, 16'h1200, 16'h1300};
    check_trace("absx_cross");
    n_cmp++; if (dc !== 5)          begin n_bad++; $display("FAIL absx_cross_cyc: got %0d want 5", dc); end
    n_cmp++; if (ea !== 16'h1300)   begin n_bad++; $display("FAIL absx_cross_ea: got %h want 1300", ea); end
    n_cmp++; if (rdata !== 8'hC3)   begin n_bad++; $display("FAIL absx_cross_rdata: got %h want c3", rdata); end
    n_cmp++; if (pc_adv !== 2'd2)   begin n_bad++; $display("FAIL absx_adv: got %0d want 2", pc_adv); end
    x = 8'h00;
    run_op(4'd5, 2'd0, 1'b0, dc);
    exp_q = '{16'h0200, 16'h0201, 16'h12FF};
    check_trace("absx_nocross");
    n_cmp++; if (dc !== 4)          begin n_bad++; $display("FAIL absx_nocross_cyc: got %0d want 4", dc); end
    n_cmp++; if (ea !== 16'h12FF)   begin n_bad++; $display("FAIL absx_nocross_ea: got %h want 12ff", ea); end
    n_cmp++; if (rdata !== 8'h3C)   begin n_bad++; $display("FAIL absx_nocross_rdata: got %h want 3c", rdata); end
    wdata = 8'h99;
    run_op(4'd5, 2'd1, 1'b0, dc);
    exp_q = '{16'h0200, 16'h0201, 16'h12FF, 16'h12FF};
    check_trace("absx_write");
    n_cmp++; if (dc !== 5)          begin n_bad++; $display("FAIL absx_wr_cyc: got %0d want 5", dc); end
    n_cmp++;
    if (tr_we.size() != 4 || tr_we[0] !== 1'b0 || tr_we[1] !== 1'b0 || tr_we[2] !== 1'b0 || tr_we[3] !== 1'b1) begin
      n_bad++; $display("FAIL absx_wr_we: got %p want 0,0,0,1", tr_we);
    end
    n_cmp++; if (mem[16'h12FF] !== 8'h99) begin n_bad++; $display("FAIL absx_wr_mem: got %h want 99", mem[16'h12FF]); end
    n_cmp++; if (rdata !== 8'h3C)   begin n_bad++; $display("FAIL absx_wr_rdata_held: got %h want 3c", rdata); end
  endtask

  task automatic test_indy;
    int dc;
    mem[16'h0200] = 8'hFF;
    mem[16'h00FF] = 8'h00;
    mem[16'h0000] = 8'h30;
    mem[16'h3005] = 8'hE7;
    y = 8'h05;
    run_op(4'd8, 2'd0, 1'b0, dc);
    exp_q = '{16'h0200, 16'h00FF, 16'h0000, 16'h3005};
    check_trace("indy");
    n_cmp++; if (dc !== 5)          begin n_bad++; $display("FAIL indy_done_cyc: got %0d want 5", dc); end
    n_cmp++; if (rdata !== 8'hE7)   begin n_bad++; $display("FAIL indy_rdata: got %h want e7", rdata); end
    n_cmp++; if (ea !== 16'h3005)   begin n_bad++; $display("FAIL indy_ea: got %h want 3005", ea); end
    n_cmp++; if (pc_adv !== 2'd1)   begin n_bad++; $display("FAIL indy_adv: got %0d want 1", pc_adv); end
  endtask

  task automatic test_rmw;
    int dc;
    mem[16'h0200] = 8'h00;
    mem[16'h0201] = 8'h30;
    mem[16'h3000] = 8'h41;
    wdata = 8'h42;
    run_op(4'd4, 2'd2, 1'b0, dc);
    exp_q = '{16'h0200, 16'h0201, 16'h3000, 16'h3000, 16'h3000};
    check_trace("rmw");
    n_cmp++; if (dc !== 6)          begin n_bad++; $display("FAIL rmw_done_cyc: got %0d want 6", dc); end
    n_cmp++;
    if (tr_we.size() != 5 || tr_we[2] !== 1'b0 || tr_we[3] !== 1'b1 || tr_we[4] !== 1'b1 || tr_we[0] !== 1'b0) begin
      n_bad++; $display("FAIL rmw_we: got %p want 0,0,0,1,1", tr_we);
    end
    n_cmp++;
    if (tr_do.size() != 5 || tr_do[3] !== 8'h41 || tr_do[4] !== 8'h42) begin
      n_bad++; $display("FAIL rmw_do: got %p want xx,xx,xx,41,42", tr_do);
    end
    n_cmp++; if (rdata !== 8'h41)   begin n_bad++; $display("FAIL rmw_rdata: got %h want 41", rdata); end
    n_cmp++; if (ea !== 16'h3000)   begin n_bad++; $display("FAIL rmw_ea: got %h want 3000", ea); end
    n_cmp++; if (mem[16'h3000] !== 8'h42) begin n_bad++; $display("FAIL rmw_mem: got %h want 42", mem[16'h3000]); end
  endtask

  task automatic test_back_to_back;
    int dc;
    mem[16'h0200] = 8'h10;
    mem[16'h0201] = 8'h40;
    mem[16'h0010] = 8'h5A;
    mem[16'h4010] = 8'h6B;
    run_op(4'd1, 2'd0, 1'b0, dc);
    n_cmp++; if (dc !== 3)          begin n_bad++; $display("FAIL b2b_first_cyc: got %0d want 3", dc); end
    run_op(4'd4, 2'd0, 1'b1, dc);
    exp_q = '{16'h0200, 16'h0201, 16'h4010};
    check_trace("b2b");
    n_cmp++; if (dc !== 4)          begin n_bad++; $display("FAIL b2b_second_cyc: got %0d want 4", dc); end
    n_cmp++; if (rdata !== 8'h6B)   begin n_bad++; $display("FAIL b2b_rdata: got %h want 6b", rdata); end
    n_cmp++; if (ea !== 16'h4010)   begin n_bad++; $display("FAIL b2b_ea: got %h want 4010", ea); end
  endtask

  task automatic test_illegal;
    int dc;
    run_op(4'hB, 2'd0, 1'b0, dc);
    n_cmp++; if (dc !== 1)          begin n_bad++; $display("FAIL ill_done_cyc: got %0d want 1", dc); end
    n_cmp++; if (tr_ab.size() !== 0) begin n_bad++; $display("FAIL ill_bus: got %0d cycles want 0", tr_ab.size()); end
    n_cmp++; if (err !== 1'b1)      begin n_bad++; $display("FAIL ill_err: got %b want 1", err); end
    n_cmp++; if (ea !== 16'h4010)   begin n_bad++; $display("FAIL ill_ea_held: got %h want 4010", ea); end
    n_cmp++; if (rdata !== 8'h6B)   begin n_bad++; $display("FAIL ill_rdata_held: got %h want 6b", rdata); end
    n_cmp++; if (pc_adv !== 2'd0)   begin n_bad++; $display("FAIL ill_adv: got %0d want 0", pc_adv); end
    n_cmp++; if (ab !== 16'h0200 || we !== 1'b0) begin n_bad++; $display("FAIL ill_idle_bus: got ab=%h we=%b want 0200/0", ab, we); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL ill_pulse: got done=%b err=%b want 0/0", done, err); end
  endtask

  task automatic test_reset_mid;
    int seen;
    mem[16'h0200] = 8'h10;
    x = 8'h04;
    @(negedge clk);
    start = 1'b1; mode = 4'd7; op = 2'd0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (dbg_state !== 4'd4) begin n_bad++; $display("FAIL mid_state: got %0d want 4", dbg_state); end
    n_cmp++; if (ab !== 16'h0014)   begin n_bad++; $display("FAIL mid_ptr0_ab: got %h want 0014", ab); end
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (we !== 1'b0)       begin n_bad++; $display("FAIL mid_we: got %b want 0", we); end
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_cmp++; if (seen !== 0)        begin n_bad++; $display("FAIL mid_no_done: got %0d active cycles want 0", seen); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset;
    test_imm;
    test_zp_read;
    test_zpx_wrap;
    test_absx;
    test_indy;
    test_rmw;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
